// File: rtl/clint_timer_pkg.sv
// Shared definitions for the machine timer: the register offsets, the
// ctrl field positions and the ctrl register layout.
package clint_pkg;

    // Byte offsets of the registers inside the timer window
    localparam logic [7:0] OFF_MTIME_LO = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI = 8'h04;
    localparam logic [7:0] OFF_CMP_LO   = 8'h08;
    localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
    localparam logic [7:0] OFF_CTRL     = 8'h10;
    localparam logic [7:0] OFF_MSIP     = 8'h14;

    // ctrl field positions; the divisor field may be up to 24 bits wide
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_MAX = 24;

    // Stored ctrl state; divisor bits above DIV_W are always held at zero
    typedef struct packed {
        logic [CTRL_DIV_MAX-1:0] div;
        logic                    en;
    } ctrl_t;

    // Software-visible 32-bit image of ctrl: enable in bit0, divisor from bit8
    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        return {c.div, 7'b0, c.en};
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Register-access port of the machine timer: one access per cycle with
// sel high, completed by ack one cycle later.
interface clint_timer_if #(
    parameter int ADDR_W = 5
);
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output sel, we, addr, wdata, input rdata, ack);
    modport slave  (input sel, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/clint_timer_prescaler.sv
// Prescaler for the machine timer: emits a one-cycle tick every
// (divisor + 1) enabled cycles; clr_i restarts the count from zero.
module clint_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             clr_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == div_i);

    // Next count: clear wins, wrap on tick, hold while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime advanced by a prescaler, 64-bit mtimecmp,
// registered timer interrupt ti = (mtime >= mtimecmp).
// Optional msip register and si output when CLINT_TIMER_MSIP_EN is defined;
// otherwise offset 0x14 is unmapped and si is tied low.
module clint_timer
    import clint_pkg::*;
#(
    parameter int          ADDR_W  = 5,
    parameter int          DIV_W   = 8,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    clint_timer_if.slave  bus,
    output logic          ti,
    output logic          si
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        ti_q;
    logic        tick;
    logic        wr;
    logic        presc_clr;
    logic [7:0]  byte_off;
    logic [31:0] rd_val;
    logic        unused_addr_lsb;

    // Word-aligned offset; the two byte-select bits do not matter
    assign byte_off        = 8'({bus.addr[ADDR_W-1:2], 2'b00});
    assign unused_addr_lsb = ^bus.addr[1:0];
    assign wr              = bus.sel && bus.we;
    assign presc_clr       = wr && (byte_off == OFF_CTRL);

    clint_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en_i   (ctrl_q.en),
        .div_i  (ctrl_q.div[DIV_W-1:0]),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

`ifdef CLINT_TIMER_MSIP_EN
    logic msip_q, msip_d;

    // msip update: only bit0 of a write to its offset is kept
    always_comb begin
        msip_d = msip_q;
        if (wr && (byte_off == OFF_MSIP)) begin
            msip_d = bus.wdata[0];
        end
    end

    // msip register and its registered si copy
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
            si     <= 1'b0;
        end else begin
            msip_q <= msip_d;
            si     <= msip_q;
        end
    end
`else
    assign si = 1'b0;
`endif

    // Read mux over pre-edge register values; unmapped offsets read 0
    always_comb begin
        rd_val = 32'h0;
        case (byte_off)
            OFF_MTIME_LO: rd_val = mtime_q[31:0];
            OFF_MTIME_HI: rd_val = mtime_q[63:32];
            OFF_CMP_LO:   rd_val = cmp_q[31:0];
            OFF_CMP_HI:   rd_val = cmp_q[63:32];
            OFF_CTRL:     rd_val = ctrl_pack(ctrl_q);
`ifdef CLINT_TIMER_MSIP_EN
            OFF_MSIP:     rd_val = {31'b0, msip_q};
`endif
            default:      rd_val = 32'h0;
        endcase
    end

    // Next state: a half-word write to mtime overrides the tick for that
    // half and the other half keeps its pre-tick value (the tick is lost)
    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr) begin
            case (byte_off)
                OFF_MTIME_LO: mtime_d = {mtime_q[63:32], bus.wdata};
                OFF_MTIME_HI: mtime_d = {bus.wdata, mtime_q[31:0]};
                OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], bus.wdata};
                OFF_CMP_HI:   cmp_d   = {bus.wdata, cmp_q[31:0]};
                OFF_CTRL: begin
                    ctrl_d.en  = bus.wdata[CTRL_EN];
                    ctrl_d.div = CTRL_DIV_MAX'(bus.wdata[CTRL_DIV_LSB +: DIV_W]);
                end
                default: ;
            endcase
        end
        ack_d   = bus.sel;
        rdata_d = (bus.sel && !bus.we) ? rd_val : 32'h0;
    end

    // State registers; ti compares the values held during the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q <= 64'd0;
            cmp_q   <= CMP_RST;
            ctrl_q  <= '{div: '0, en: 1'b1};
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            ti_q    <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ti_q    <= (mtime_q >= cmp_q);
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign ti        = ti_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: table of register accesses plus
// hand-written timing sequences; read expectations go through a scoreboard.
module tb_clint_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ti;
    logic si;

    clint_timer_if #(.ADDR_W(5)) bus ();

    clint_timer #(
        .ADDR_W  (5),
        .DIV_W   (8),
        .CMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .ti  (ti),
        .si  (si)
    );

    always #5 clk = ~clk;

`ifdef CLINT_TIMER_MSIP_EN
    localparam logic MSIP_ON = 1'b1;
`else
    localparam logic MSIP_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        int          issue;
    } sb_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t vecs[17];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got %h", nm, act);
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Acknowledge monitor: pops one expectation per ack and checks data and latency
    always @(posedge clk) begin
        #1;
        if (bus.ack === 1'b1) begin
            chk_cnt++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_ack: rdata %h with no access pending", bus.rdata);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.rdata >= mon_e.lo && bus.rdata <= mon_e.hi && cyc == mon_e.issue + 1) begin
                    pass_cnt++;
                    $display("ack %s: rdata %h", mon_e.name, bus.rdata);
                end else begin
                    $display("FAIL %s: rdata %h at cycle %0d, expected %h..%h at cycle %0d",
                             mon_e.name, bus.rdata, cyc, mon_e.lo, mon_e.hi, mon_e.issue + 1);
                end
            end
        end
    end

    // One access on the next negedge; sel stays high until idle() or the next acc()
    task automatic acc(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] lo, input logic [31:0] hi, input string nm);
        sb_t e;
        @(negedge clk);
        bus.sel   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        e.name  = nm;
        e.lo    = w ? 32'h0 : lo;
        e.hi    = w ? 32'h0 : hi;
        e.issue = cyc;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sel = 1'b0;
        bus.we  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'h10, 32'h0000_0000, 32'h0};
        vecs[1]  = '{1'b1, 5'h00, 32'h1234_5678, 32'h0};
        vecs[2]  = '{1'b1, 5'h04, 32'hCAFE_0001, 32'h0};
        vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'h1234_5678};
        vecs[4]  = '{1'b0, 5'h04, 32'h0,         32'hCAFE_0001};
        vecs[5]  = '{1'b0, 5'h03, 32'h0,         32'h1234_5678};
        vecs[6]  = '{1'b1, 5'h08, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{1'b1, 5'h0C, 32'h0000_0002, 32'h0};
        vecs[8]  = '{1'b0, 5'h08, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 5'h0C, 32'h0,         32'h0000_0002};
        vecs[10] = '{1'b1, 5'h10, 32'hFFFF_FF00, 32'h0};
        vecs[11] = '{1'b0, 5'h10, 32'h0,         32'h0000_FF00};
        vecs[12] = '{1'b1, 5'h18, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 5'h18, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 5'h1C, 32'h0,         32'h0};
        vecs[15] = '{1'b1, 5'h10, 32'h0000_0000, 32'h0};
        vecs[16] = '{1'b0, 5'h10, 32'h0,         32'h0};

        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, bus.ack}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_ti", {31'b0, ti}, 32'h0);
        check("rst_si", {31'b0, si}, 32'h0);

        // First accesses right after reset: mtime still 0, mtimecmp high all ones
        @(negedge clk);
        rst = 1'b0;
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 5'h00;
        sbq.push_back('{"rd_mtime_lo_after_rst", 32'h0, 32'h0, cyc});
        acc(1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rd_cmp_hi_after_rst");
        idle();
        check("ti_after_rst", {31'b0, ti}, 32'h0);

        // Register map table with the timer stopped
        for (int i = 0; i < 17; i++) begin
            acc(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].exp,
                $sformatf("vec%0d_%s_%h", i, vecs[i].we ? "wr" : "rd", vecs[i].addr));
        end
        idle();
        repeat (2) @(negedge clk);
        check("ti_mtime_above_cmp", {31'b0, ti}, 32'h1);

        // Prescaler divisor 3: about one mtime step per 4 cycles
        acc(1'b1, 5'h00, 32'h0, 32'h0, 32'h0, "wr_mtime_lo0");
        acc(1'b1, 5'h04, 32'h0, 32'h0, 32'h0, "wr_mtime_hi0");
        acc(1'b1, 5'h10, 32'h0000_0301, 32'h0, 32'h0, "wr_ctrl_div3");
        idle();
        repeat (40) @(negedge clk);
        acc(1'b0, 5'h00, 32'h0, 32'd9, 32'd11, "rd_mtime_div3_40cyc");
        idle();

        // Low-to-high carry in one cycle
        acc(1'b1, 5'h10, 32'h0, 32'h0, 32'h0, "wr_ctrl_stop");
        acc(1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0, 32'h0, "wr_mtime_lo_ff");
        acc(1'b1, 5'h04, 32'h0, 32'h0, 32'h0, "wr_mtime_hi_0");
        acc(1'b1, 5'h10, 32'h1, 32'h0, 32'h0, "wr_ctrl_div0");
        idle();
        idle();
        acc(1'b0, 5'h04, 32'h0, 32'h1, 32'h1, "rd_mtime_hi_carry");
        acc(1'b0, 5'h00, 32'h0, 32'h0, 32'd10, "rd_mtime_lo_carry");
        idle();

        // ti rises one cycle after mtime reaches mtimecmp = 20
        acc(1'b1, 5'h10, 32'h0, 32'h0, 32'h0, "wr_ctrl_stop2");
        acc(1'b1, 5'h00, 32'h0, 32'h0, 32'h0, "wr_mtime_lo_z");
        acc(1'b1, 5'h04, 32'h0, 32'h0, 32'h0, "wr_mtime_hi_z");
        acc(1'b1, 5'h08, 32'd20, 32'h0, 32'h0, "wr_cmp_lo_20");
        acc(1'b1, 5'h0C, 32'h0, 32'h0, 32'h0, "wr_cmp_hi_0");
        acc(1'b1, 5'h10, 32'h1, 32'h0, 32'h0, "wr_ctrl_run");
        for (int k = 0; k <= 22; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.sel = 1'b0;
                bus.we  = 1'b0;
            end
            check($sformatf("ti_edge%0d", k), {31'b0, ti}, (k >= 21) ? 32'h1 : 32'h0);
        end

        // Raising mtimecmp drops ti one cycle after the write edge
        acc(1'b1, 5'h0C, 32'h1, 32'h0, 32'h0, "wr_cmp_hi_1");
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        check("ti_at_cmp_write_edge", {31'b0, ti}, 32'h1);
        @(posedge clk);
        #1;
        check("ti_after_cmp_raise", {31'b0, ti}, 32'h0);

        // Write to mtime low word while a tick is due: written value, no +1
        acc(1'b1, 5'h10, 32'h0, 32'h0, 32'h0, "wr_ctrl_stop3");
        acc(1'b1, 5'h04, 32'h7, 32'h0, 32'h0, "wr_mtime_hi_7");
        acc(1'b1, 5'h10, 32'h1, 32'h0, 32'h0, "wr_ctrl_run2");
        idle();
        acc(1'b1, 5'h00, 32'h5555_0000, 32'h0, 32'h0, "wr_mtime_lo_on_tick");
        acc(1'b0, 5'h00, 32'h0, 32'h5555_0000, 32'h5555_0000, "rd_mtime_lo_no_inc");
        acc(1'b0, 5'h04, 32'h0, 32'h7, 32'h7, "rd_mtime_hi_kept");
        idle();

        // Software interrupt register
        acc(1'b1, 5'h14, 32'h1, 32'h0, 32'h0, "wr_msip_1");
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        check("si_at_write_edge", {31'b0, si}, 32'h0);
        @(posedge clk);
        #1;
        check("si_after_write", {31'b0, si}, {31'b0, MSIP_ON});
        acc(1'b0, 5'h14, 32'h0, {31'b0, MSIP_ON}, {31'b0, MSIP_ON}, "rd_msip");
        idle();

        // Reset during an access: no ack follows
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 5'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_dropped_by_rst", {31'b0, bus.ack}, 32'h0);
        check("ti_cleared_by_rst", {31'b0, ti}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.sel = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_acks", sbq.size(), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
